crc32_byte_sequencer: RTL and testbench

CRC32_BYTE_SEQUENCER -- requirements
Module: crc32_byte_sequencer

---
 rtl/crc32_seq_if.sv | 36 +++
 rtl/crc32_byte_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_crc32_byte_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc32_seq_if.sv
// crc32_seq_if
//   Groups the host write handshake and the CRC engine byte interface used by
//   crc32_byte_sequencer.
//
//   Host side : wr_valid, wr_ready, wr_data[31:0], wr_len[2:0], wr_last
//   Engine side: crc_trigger, crc_byte[7:0], crc_busy, done_pulse,
//                crc_result[31:0], data_done
//
//   Modports:
//     master - the environment (host + engine) driving the sequencer
//     slave  - the sequencer itself
interface crc32_seq_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [2:0]  wr_len;
  logic        wr_last;
  logic        crc_trigger;
  logic [7:0]  crc_byte;
  logic        crc_busy;
  logic        done_pulse;
  logic [31:0] crc_result;
  logic        data_done;

  modport master (
    output wr_valid, wr_data, wr_len, wr_last,
    output crc_busy, done_pulse, crc_result,
    input  wr_ready, crc_trigger, crc_byte, data_done
  );

  modport slave (
    input  wr_valid, wr_data, wr_len, wr_last,
    input  crc_busy, done_pulse, crc_result,
    output wr_ready, crc_trigger, crc_byte, data_done
  );
endinterface

// File: rtl/crc32_byte_sequencer.sv
// crc32_byte_sequencer
//   Accepts 32-bit words (1..4 valid bytes, byte 0 first) from a host and
//   feeds them one byte at a time to a CRC32 engine, waiting for the engine's
//   done_pulse between bytes. On the last byte of a message the engine's
//   result is captured and data_done is pulsed. A per-byte watchdog aborts
//   the message if the engine never answers.
//
//   Ports:
//     clk_i, rst_n_i   clock, synchronous active-low reset
//     bus (slave)      host write handshake + engine byte interface
//     result_o         CRC of the last finished message
//     result_valid_o   result_o holds a completed message CRC
//     seq_busy_o       high whenever the sequencer is not IDLE
//     byte_count_o     bytes fed in the current/last message (saturating)
//     timeout_err_o    sticky: engine failed to answer within TIMEOUT_CYCLES
//     state_o          current FSM state (debug)
//
//   Handshake: a word transfers on a rising edge where wr_valid && wr_ready.
//   wr_ready is high only in IDLE and never depends on wr_valid; the host
//   holds wr_valid/wr_data/wr_len/wr_last stable until the transfer.
module crc32_byte_sequencer #(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  crc32_seq_if.slave       bus,
  output logic [31:0]      result_o,
  output logic             result_valid_o,
  output logic             seq_busy_o,
  output logic [CNT_W-1:0] byte_count_o,
  output logic             timeout_err_o,
  output logic [1:0]       state_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       last_idx_q, last_idx_d;   // wr_len - 1
  logic             last_q, last_d;
  logic [1:0]       idx_q, idx_d;
  logic             open_q, open_d;           // a message is in progress
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [31:0]      result_q, result_d;
  logic             rv_q, rv_d;
  logic             terr_q, terr_d;

  logic             wr_ready;
  logic             trigger;
  logic             data_done;
  logic [1:0]       len_dec;

  // Lengths outside 1..4 are treated as a full word.
  always_comb begin
    case (bus.wr_len)
      3'd1:    len_dec = 2'd0;
      3'd2:    len_dec = 2'd1;
      3'd3:    len_dec = 2'd2;
      default: len_dec = 2'd3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    last_idx_d = last_idx_q;
    last_d     = last_q;
    idx_d      = idx_q;
    open_d     = open_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    result_d   = result_q;
    rv_d       = rv_q;
    terr_d     = terr_q;
    wr_ready   = 1'b0;
    trigger    = 1'b0;
    data_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          data_d     = bus.wr_data;
          last_idx_d = len_dec;
          last_d     = bus.wr_last;
          idx_d      = 2'd0;
          open_d     = 1'b1;
          // First word of a new message restarts the count and
          // invalidates the previous result.
          if (!open_q) begin
            cnt_d = '0;
            rv_d  = 1'b0;
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        trigger = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.done_pulse) begin
          if (idx_q == last_idx_q) begin
            // Non-last words return to IDLE with the message still open.
            state_d = last_q ? S_FINISH : S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th cycle without an answer: abort.
          terr_d    = 1'b1;
          rv_d      = 1'b0;
          data_done = 1'b1;
          open_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_FINISH: begin
        // Capture happens on the same edge the engine sees data_done, so
        // the value is taken before the engine reinitialises.
        result_d  = bus.crc_result;
        rv_d      = 1'b1;
        data_done = 1'b1;
        open_d    = 1'b0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      last_idx_q <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      open_q     <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      result_q   <= '0;
      rv_q       <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      last_idx_q <= last_idx_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      open_q     <= open_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      result_q   <= result_d;
      rv_q       <= rv_d;
      terr_q     <= terr_d;
    end
  end

  // Byte select follows the registered index, so it is stable from the
  // trigger cycle through the whole WAIT period.
  assign bus.crc_byte    = data_q[{idx_q, 3'b000} +: 8];
  assign bus.wr_ready    = wr_ready;
  assign bus.crc_trigger = trigger;
  assign bus.data_done   = data_done;

  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign seq_busy_o     = (state_q != S_IDLE);
  assign byte_count_o   = cnt_q;
  assign timeout_err_o  = terr_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_crc32_byte_sequencer.sv
module tb_crc32_byte_sequencer;

  localparam logic [1:0] ST_IDLE = 2'd0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  crc32_seq_if bus ();

  logic [31:0] result;
  logic        result_valid;
  logic        seq_busy;
  logic [15:0] byte_count;
  logic        timeout_err;
  logic [1:0]  state;

  crc32_byte_sequencer #(.TIMEOUT_CYCLES(32), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .bus            (bus.slave),
    .result_o       (result),
    .result_valid_o (result_valid),
    .seq_busy_o     (seq_busy),
    .byte_count_o   (byte_count),
    .timeout_err_o  (timeout_err),
    .state_o        (state)
  );

  // ---------------- CRC engine model ----------------
  // Reflected CRC-32, init all-ones, post-xor; done_pulse 11 cycles after
  // the trigger cycle.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [31:0] eng_crc;
  logic [3:0]  eng_cnt;
  logic        eng_done;
  logic        eng_busy;
  logic        stub_mode = 1'b0;
  logic        spur_done = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      eng_crc  <= 32'hFFFFFFFF;
      eng_cnt  <= 4'd0;
      eng_done <= 1'b0;
      eng_busy <= 1'b0;
    end else begin
      eng_done <= (eng_cnt == 4'd1) && !stub_mode;
      if (bus.crc_trigger) begin
        eng_crc  <= crc_upd(eng_crc, bus.crc_byte);
        eng_cnt  <= 4'd10;
        eng_busy <= 1'b1;
      end else if (eng_cnt != 4'd0) begin
        eng_cnt <= eng_cnt - 4'd1;
        if (eng_cnt == 4'd1) eng_busy <= 1'b0;
      end
      if (bus.data_done) eng_crc <= 32'hFFFFFFFF;
    end
  end

  assign bus.done_pulse = eng_done | spur_done;
  assign bus.crc_busy   = eng_busy;
  assign bus.crc_result = ~eng_crc;

  // ---------------- monitor ----------------
  int         trig_cnt = 0;
  int         dd_cnt   = 0;
  int         dd_cyc   = 0;
  int         overlap  = 0;
  int         trig_cyc_q[$];
  logic [7:0] trig_byte_q[$];

  always @(negedge clk) begin
    if (bus.crc_trigger) begin
      trig_cnt++;
      trig_cyc_q.push_back(cyc);
      trig_byte_q.push_back(bus.crc_byte);
    end
    if (bus.data_done) begin
      dd_cnt++;
      dd_cyc = cyc;
    end
    if (bus.crc_trigger && bus.data_done) overlap++;
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    @(posedge clk);
    trig_cnt = 0;
    dd_cnt   = 0;
    trig_cyc_q.delete();
    trig_byte_q.delete();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge just after the transfer.
  task automatic send_word(input logic [31:0] d, input logic [2:0] l, input logic last);
    int n;
    bus.wr_data  = d;
    bus.wr_len   = l;
    bus.wr_last  = last;
    bus.wr_valid = 1'b1;
    n = 0;
    while (!bus.wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.wr_ready) begin
      n_checks++;
      $display("FAIL send_word: wr_ready stayed %0b, required 1", bus.wr_ready);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (seq_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (seq_busy) begin
      n_checks++;
      $display("FAIL %s_idle_timeout: seq_busy=%0b required 0", name, seq_busy);
    end
  endtask

  task automatic check_bytes(input string name);
    n_checks++;
    if (trig_byte_q.size() != exp_q.size()) begin
      $display("FAIL %s_nbytes: got %0d required %0d", name, trig_byte_q.size(), exp_q.size());
      exp_q.delete();
    end else n_pass++;
    while (exp_q.size() > 0 && trig_byte_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = trig_byte_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL %s_byte: got %h required %h", name, g, e);
      else n_pass++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (state !== ST_IDLE) $display("FAIL rst_state: got %0d required 0", state); else n_pass++;
    n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL rst_wr_ready: got %b required 1", bus.wr_ready); else n_pass++;
    n_checks++; if (bus.crc_trigger !== 1'b0) $display("FAIL rst_trigger: got %b required 0", bus.crc_trigger); else n_pass++;
    n_checks++; if (bus.data_done !== 1'b0) $display("FAIL rst_data_done: got %b required 0", bus.data_done); else n_pass++;
    n_checks++; if (bus.crc_byte !== 8'h00) $display("FAIL rst_crc_byte: got %h required 00", bus.crc_byte); else n_pass++;
    n_checks++; if (seq_busy !== 1'b0) $display("FAIL rst_seq_busy: got %b required 0", seq_busy); else n_pass++;
    n_checks++; if (result !== 32'h0) $display("FAIL rst_result: got %h required 0", result); else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL rst_result_valid: got %b required 0", result_valid); else n_pass++;
    n_checks++; if (byte_count !== 16'd0) $display("FAIL rst_byte_count: got %0d required 0", byte_count); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b required 0", timeout_err); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_check_string();
    clear_mon();
    send_word(32'h34333231, 3'd4, 1'b0);
    wait_idle("chk_w0");
    send_word(32'h38373635, 3'd4, 1'b0);
    wait_idle("chk_w1");
    send_word(32'h00000039, 3'd1, 1'b1);
    wait_idle("chk_w2");
    n_checks++; if (result !== 32'hCBF43926) $display("FAIL chk_result: got %h required cbf43926", result); else n_pass++;
    n_checks++; if (result_valid !== 1'b1) $display("FAIL chk_result_valid: got %b required 1", result_valid); else n_pass++;
    n_checks++; if (byte_count !== 16'd9) $display("FAIL chk_byte_count: got %0d required 9", byte_count); else n_pass++;
    n_checks++; if (dd_cnt !== 1) $display("FAIL chk_data_done_cnt: got %0d required 1", dd_cnt); else n_pass++;
    n_checks++; if (trig_cnt !== 9) $display("FAIL chk_trigger_cnt: got %0d required 9", trig_cnt); else n_pass++;
  endtask

  task automatic test_single_byte();
    clear_mon();
    send_word(32'h00000031, 3'd1, 1'b1);
    wait_idle("single");
    n_checks++; if (trig_cnt !== 1) $display("FAIL single_trigger_cnt: got %0d required 1", trig_cnt); else n_pass++;
    n_checks++; if (dd_cnt !== 1) $display("FAIL single_data_done_cnt: got %0d required 1", dd_cnt); else n_pass++;
    n_checks++; if (byte_count !== 16'd1) $display("FAIL single_byte_count: got %0d required 1", byte_count); else n_pass++;
    n_checks++; if (result_valid !== 1'b1) $display("FAIL single_result_valid: got %b required 1", result_valid); else n_pass++;
    n_checks++; if (result !== 32'h83DCEFB7) $display("FAIL single_result: got %h required 83dcefb7", result); else n_pass++;
  endtask

  task automatic test_trigger_spacing();
    clear_mon();
    send_word(32'h34333231, 3'd4, 1'b1);
    // Accepting the first word of a new message drops the old result_valid.
    n_checks++; if (result_valid !== 1'b0) $display("FAIL space_rv_cleared: got %b required 0", result_valid); else n_pass++;
    wait_idle("space");
    n_checks++; if (trig_cnt !== 4) $display("FAIL space_trigger_cnt: got %0d required 4", trig_cnt); else n_pass++;
    for (int i = 1; i < trig_cyc_q.size(); i++) begin
      n_checks++;
      if (trig_cyc_q[i] - trig_cyc_q[i-1] !== 12)
        $display("FAIL space_gap%0d: got %0d cycles required 12", i, trig_cyc_q[i] - trig_cyc_q[i-1]);
      else n_pass++;
    end
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    check_bytes("space");
    n_checks++; if (dd_cnt !== 1) $display("FAIL space_data_done_cnt: got %0d required 1", dd_cnt); else n_pass++;
  endtask

  task automatic test_spurious_len0();
    clear_mon();
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    n_checks++; if (state !== ST_IDLE) $display("FAIL spur_state: got %0d required 0", state); else n_pass++;
    @(negedge clk);
    n_checks++; if (trig_cnt !== 0) $display("FAIL spur_trigger_cnt: got %0d required 0", trig_cnt); else n_pass++;
    n_checks++; if (seq_busy !== 1'b0) $display("FAIL spur_seq_busy: got %b required 0", seq_busy); else n_pass++;
    send_word(32'h34333231, 3'd0, 1'b1);
    wait_idle("len0");
    n_checks++; if (trig_cnt !== 4) $display("FAIL len0_trigger_cnt: got %0d required 4", trig_cnt); else n_pass++;
    n_checks++; if (byte_count !== 16'd4) $display("FAIL len0_byte_count: got %0d required 4", byte_count); else n_pass++;
    n_checks++; if (result_valid !== 1'b1) $display("FAIL len0_result_valid: got %b required 1", result_valid); else n_pass++;
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    check_bytes("len0");
  endtask

  task automatic test_timeout();
    clear_mon();
    stub_mode = 1'b1;
    send_word(32'h00000031, 3'd1, 1'b1);
    wait_idle("tmo");
    stub_mode = 1'b0;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL tmo_err: got %b required 1", timeout_err); else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL tmo_result_valid: got %b required 0", result_valid); else n_pass++;
    n_checks++; if (dd_cnt !== 1) $display("FAIL tmo_data_done_cnt: got %0d required 1", dd_cnt); else n_pass++;
    n_checks++; if (state !== ST_IDLE) $display("FAIL tmo_state: got %0d required 0", state); else n_pass++;
    n_checks++; if (trig_cnt !== 1) $display("FAIL tmo_trigger_cnt: got %0d required 1", trig_cnt); else n_pass++;
    if (trig_cyc_q.size() > 0) begin
      n_checks++;
      if (dd_cyc - trig_cyc_q[0] !== 32)
        $display("FAIL tmo_latency: got %0d cycles required 32", dd_cyc - trig_cyc_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mon();
    send_word(32'h34333231, 3'd4, 1'b0);
    n = 0;
    while (trig_cnt < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (trig_cnt !== 2) $display("FAIL rmid_reach_byte2: got %0d triggers required 2", trig_cnt); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== ST_IDLE) $display("FAIL rmid_state: got %0d required 0", state); else n_pass++;
    n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL rmid_wr_ready: got %b required 1", bus.wr_ready); else n_pass++;
    n_checks++; if (bus.crc_byte !== 8'h00) $display("FAIL rmid_crc_byte: got %h required 00", bus.crc_byte); else n_pass++;
    n_checks++; if (seq_busy !== 1'b0) $display("FAIL rmid_seq_busy: got %b required 0", seq_busy); else n_pass++;
    n_checks++; if (byte_count !== 16'd0) $display("FAIL rmid_byte_count: got %0d required 0", byte_count); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL rmid_timeout_err: got %b required 0", timeout_err); else n_pass++;
    n_checks++; if (result !== 32'h0) $display("FAIL rmid_result: got %h required 0", result); else n_pass++;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    n_checks++; if (dd_cnt !== 0) $display("FAIL rmid_no_data_done: got %0d required 0", dd_cnt); else n_pass++;
    n_checks++; if (trig_cnt !== 2) $display("FAIL rmid_no_more_triggers: got %0d required 2", trig_cnt); else n_pass++;
    // A fresh message after the drop starts clean.
    send_word(32'h00000031, 3'd1, 1'b1);
    wait_idle("rmid_after");
    n_checks++; if (result !== 32'h83DCEFB7) $display("FAIL rmid_after_result: got %h required 83dcefb7", result); else n_pass++;
    n_checks++; if (byte_count !== 16'd1) $display("FAIL rmid_after_byte_count: got %0d required 1", byte_count); else n_pass++;
  endtask

  task automatic test_no_overlap();
    n_checks++;
    if (overlap !== 0) $display("FAIL no_overlap: got %0d overlapping cycles required 0", overlap);
    else n_pass++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 32'h0;
    bus.wr_len   = 3'd0;
    bus.wr_last  = 1'b0;
    @(negedge clk);
    test_reset();
    test_check_string();
    test_single_byte();
    test_trigger_spacing();
    test_spurious_len0();
    test_timeout();
    test_reset_mid();
    test_no_overlap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
